// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader:
// FSM state encoding, byte-lane geometry and the length-prefix size.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } boot_state_e;

  localparam int          BOOT_LEN_BYTES = 2;
  localparam int          LANE_W         = 8;
  localparam int          LANES          = 4;
  localparam logic [1:0]  LANE_FIRST     = 2'd0;
  localparam logic [1:0]  LANE_LAST      = 2'(LANES - 1);

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the boot loader.
// master = stream source / memory side, slave = the loader itself.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs four accepted bytes into one little-endian 32-bit word; 'full' marks
// the cycle whose byte completes the word, with 'word' valid alongside it.
module byte_word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0]                  cnt_q;
  logic [(LANES-1)*LANE_W-1:0] sreg_q;

  assign full = in_en && (cnt_q == LANE_LAST);
  assign word = {in_byte, sreg_q};

  // NOTE: non-blocking so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= LANE_FIRST;
      sreg_q <= '0;
    end else if (in_en) begin
      // Earlier bytes drift toward the low lanes; the count wraps 3 -> 0.
      sreg_q <= {in_byte, sreg_q[(LANES-1)*LANE_W-1:LANE_W]};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Length-prefixed byte-stream loader: writes words to instruction memory,
// then releases the CPU reset after a settle interval.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  imem_boot_loader_if.slave bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int         HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  boot_state_e       state_q, state_d;
  logic              ready_q, ready_d;
  logic [7:0]        len_lo_q;
  logic [15:0]       words_left_q;
  logic [ADDR_W-1:0] addr_q;
  logic [HOLD_W-1:0] hold_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              cpu_rst_q, done_q, err_q;

  logic              accept;
  logic [16:0]       len_n;
  logic              pk_en, pk_full;
  logic [31:0]       pk_word;

  assign accept = bus.in_valid && ready_q;
  assign len_n  = {1'b0, bus.in_data, len_lo_q};
  assign pk_en  = accept && (state_q == ST_DATA);

  byte_word_packer u_packer (
    .clk     (clk_in),
    .rst_n   (rst),
    .in_en   (pk_en),
    .in_byte (bus.in_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  // NOTE: defaults first so every path assigns every output (no inferred latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LEN_LO: if (accept) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (len_n == 17'd0)        state_d = ST_HOLD;
          else if (len_n > CAPACITY) state_d = ST_ERR;
          else                       state_d = ST_DATA;
        end
      end
      ST_DATA:   if (pk_full && (words_left_q == 16'd1)) state_d = ST_HOLD;
      ST_HOLD:   if (hold_q == '0) state_d = ST_RUN;
      ST_RUN:    state_d = ST_RUN;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_LEN_LO;
    endcase
    ready_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) || (state_d == ST_DATA);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LEN_LO;
      ready_q      <= 1'b0;
      len_lo_q     <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      hold_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      cpu_rst_q <= (state_d != ST_RUN);
      done_q    <= (state_d == ST_RUN);
      err_q     <= (state_d == ST_ERR);
      we_q      <= pk_full;

      if (state_q == ST_LEN_LO && accept) len_lo_q <= bus.in_data;
      if (state_q == ST_LEN_HI && accept) words_left_q <= len_n[15:0];

      if (pk_full) begin
        waddr_q      <= addr_q;
        wdata_q      <= pk_word;
        addr_q       <= addr_q + ADDR_W'(1);
        words_left_q <= words_left_q - 16'd1;
      end

      // The extra count after a data load covers the registered write strobe,
      // so release lands HOLD_CYCLES edges after the strobe is seen high.
      if (state_q != ST_HOLD && state_d == ST_HOLD)
        hold_q <= (state_q == ST_DATA) ? HOLD_W'(HOLD_CYCLES) : HOLD_W'(HOLD_CYCLES - 1);
      else if (state_q == ST_HOLD && hold_q != '0)
        hold_q <= hold_q - HOLD_W'(1);
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a 1K-word instance and a 4-word
// instance, expected writes queued as bytes are driven and popped on strobes.
module tb_imem_boot_loader;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  imem_boot_loader_if #(.ADDR_W(10)) a_if ();
  imem_boot_loader_if #(.ADDR_W(2))  b_if ();

  logic a_cpu_rst, a_done, a_err;
  logic b_cpu_rst, b_done, b_err;

  imem_boot_loader #(.ADDR_W(10), .HOLD_CYCLES(HOLD)) dut_a (
    .clk_in (clk), .rst (rst_a), .bus (a_if.slave),
    .cpu_rst (a_cpu_rst), .done (a_done), .err (a_err)
  );

  imem_boot_loader #(.ADDR_W(2), .HOLD_CYCLES(HOLD)) dut_b (
    .clk_in (clk), .rst (rst_b), .bus (b_if.slave),
    .cpu_rst (b_cpu_rst), .done (b_done), .err (b_err)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  a_we_t[$];
  int  b_we_t[$];
  int  a_we_cnt = 0, b_we_cnt = 0;
  int  a_fall = -1, b_fall = -1;
  int  exp_addr_a = 0, exp_addr_b = 0;
  int  last_acc = 0;
  int  n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitors sample on the falling edge, half a cycle clear of the DUT's edge.
  initial begin
    wr_t w;
    logic prev = 1'b1;
    forever begin
      @(negedge clk);
      if (a_if.imem_we === 1'b1) begin
        check("a_we_expected", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          w = qa.pop_front();
          check("a_addr", 64'(a_if.imem_addr), 64'(w.addr));
          check("a_data", 64'(a_if.imem_wdata), 64'(w.data));
        end
        a_we_cnt++;
        a_we_t.push_back(cyc);
      end
      if (prev && !a_cpu_rst) a_fall = cyc;
      prev = a_cpu_rst;
    end
  end

  initial begin
    wr_t w;
    logic prev = 1'b1;
    forever begin
      @(negedge clk);
      if (b_if.imem_we === 1'b1) begin
        check("b_we_expected", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          w = qb.pop_front();
          check("b_addr", 64'(b_if.imem_addr), 64'(w.addr));
          check("b_data", 64'(b_if.imem_wdata), 64'(w.data));
        end
        b_we_cnt++;
        b_we_t.push_back(cyc);
      end
      if (prev && !b_cpu_rst) b_fall = cyc;
      prev = b_cpu_rst;
    end
  end

  function automatic logic rdy(input bit sel);
    return sel ? b_if.in_ready : a_if.in_ready;
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin b_if.in_valid = v; b_if.in_data = d; end
    else     begin a_if.in_valid = v; a_if.in_data = d; end
  endtask

  // Asserts reset mid-cycle and checks that outputs clear with no clock edge.
  task automatic do_reset(input bit sel);
    @(negedge clk);
    #2;
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    set_in(sel, 1'b0, 8'h00);
    #1;
    check("rst_in_ready", 64'(sel ? b_if.in_ready   : a_if.in_ready),   64'd0);
    check("rst_we",       64'(sel ? b_if.imem_we    : a_if.imem_we),    64'd0);
    check("rst_addr",     sel ? 64'(b_if.imem_addr) : 64'(a_if.imem_addr), 64'd0);
    check("rst_wdata",    64'(sel ? b_if.imem_wdata : a_if.imem_wdata), 64'd0);
    check("rst_cpu_rst",  64'(sel ? b_cpu_rst : a_cpu_rst), 64'd1);
    check("rst_done",     64'(sel ? b_done    : a_done),    64'd0);
    check("rst_err",      64'(sel ? b_err     : a_err),     64'd0);
    if (sel) begin b_we_cnt = 0; b_we_t.delete(); b_fall = -1; exp_addr_b = 0; end
    else     begin a_we_cnt = 0; a_we_t.delete(); a_fall = -1; exp_addr_a = 0; end
    @(negedge clk);
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(rdy(sel)), 64'd1);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    int t = 0;
    set_in(sel, 1'b1, b);
    while (!rdy(sel) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rdy(sel)) check("ready_timeout", 64'(rdy(sel)), 64'd1);
    last_acc = cyc + 1;
    @(negedge clk);
    set_in(sel, 1'b0, 8'h00);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_len(input bit sel, input logic [15:0] n, input int gap);
    send_byte(sel, n[7:0], gap);
    send_byte(sel, n[15:8], gap);
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w, input int gap);
    wr_t e;
    send_byte(sel, w[7:0], gap);
    send_byte(sel, w[15:8], gap);
    send_byte(sel, w[23:16], gap);
    if (sel) begin
      e.addr = 16'(exp_addr_b); e.data = w; qb.push_back(e); exp_addr_b++;
    end else begin
      e.addr = 16'(exp_addr_a); e.data = w; qa.push_back(e); exp_addr_a++;
    end
    send_byte(sel, w[31:24], gap);
  endtask

  task automatic wait_done(input bit sel);
    int t = 0;
    while (!(sel ? b_done : a_done) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done_wait", 64'(sel ? b_done : a_done), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int ready_hi;
    set_in(1'b0, 1'b0, 8'h00);
    set_in(1'b1, 1'b0, 8'h00);

    // Two words at full rate, then extra bytes that must stall.
    do_reset(1'b0);
    send_len(1'b0, 16'd2, 0);
    send_word(1'b0, 32'h0000_0013, 0);
    send_word(1'b0, 32'h0010_0093, 0);
    wait_done(1'b0);
    check("full_we_cnt", 64'(a_we_cnt), 64'd2);
    if (a_we_t.size() == 2) begin
      check("full_spacing", 64'(a_we_t[1] - a_we_t[0]), 64'd4);
      check("full_release", 64'(a_fall - a_we_t[1]), 64'(HOLD + 1));
    end else check("full_we_times", 64'(a_we_t.size()), 64'd2);
    check("full_cpu_rst", 64'(a_cpu_rst), 64'd0);
    ready_hi = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 8'(8'hA0 + i));
      repeat (3) begin
        @(negedge clk);
        if (a_if.in_ready) ready_hi++;
      end
    end
    set_in(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("extra_ready", 64'(ready_hi), 64'd0);
    check("extra_we_cnt", 64'(a_we_cnt), 64'd2);
    check("extra_done", 64'(a_done), 64'd1);

    // Same stream with in_valid toggling every other cycle.
    do_reset(1'b0);
    send_len(1'b0, 16'd2, 1);
    send_word(1'b0, 32'h0000_0013, 1);
    send_word(1'b0, 32'h0010_0093, 1);
    wait_done(1'b0);
    check("gap_we_cnt", 64'(a_we_cnt), 64'd2);
    if (a_we_t.size() == 2) begin
      check("gap_spacing", 64'(a_we_t[1] - a_we_t[0]), 64'd8);
      check("gap_release", 64'(a_fall - a_we_t[1]), 64'(HOLD + 1));
    end else check("gap_we_times", 64'(a_we_t.size()), 64'd2);

    // Empty program: hold interval counted from the high length byte.
    do_reset(1'b0);
    send_len(1'b0, 16'd0, 0);
    wait_done(1'b0);
    check("zero_release", 64'(a_fall - last_acc), 64'(HOLD));
    check("zero_we_cnt", 64'(a_we_cnt), 64'd0);
    check("zero_ready", 64'(a_if.in_ready), 64'd0);

    // Reset in the middle of word 1, then reload one word.
    do_reset(1'b0);
    send_len(1'b0, 16'd2, 0);
    send_word(1'b0, 32'h1122_3344, 0);
    send_byte(1'b0, 8'h55, 0);
    send_byte(1'b0, 8'h66, 0);
    do_reset(1'b0);
    send_len(1'b0, 16'd1, 0);
    send_word(1'b0, 32'hDEAD_BEEF, 0);
    wait_done(1'b0);
    check("reload_we_cnt", 64'(a_we_cnt), 64'd1);
    check("reload_q_empty", 64'(qa.size()), 64'd0);

    // Four-word memory: five words overflows, four fills it exactly.
    do_reset(1'b1);
    send_len(1'b1, 16'd5, 0);
    repeat (HOLD + 6) @(negedge clk);
    check("ovf_err", 64'(b_err), 64'd1);
    check("ovf_cpu_rst", 64'(b_cpu_rst), 64'd1);
    check("ovf_ready", 64'(b_if.in_ready), 64'd0);
    check("ovf_done", 64'(b_done), 64'd0);
    check("ovf_we_cnt", 64'(b_we_cnt), 64'd0);

    do_reset(1'b1);
    send_len(1'b1, 16'd4, 0);
    for (int i = 0; i < 4; i++) send_word(1'b1, 32'hC0DE_0000 + 32'(i * 17), 0);
    wait_done(1'b1);
    check("cap_we_cnt", 64'(b_we_cnt), 64'd4);
    check("cap_err", 64'(b_err), 64'd0);
    check("cap_q_empty", 64'(qb.size()), 64'd0);
    repeat (4) @(negedge clk);
    check("cap_no_wrap", 64'(b_we_cnt), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time loader between the simulation/board stimulus and the `top` CPU core. It accepts a length-prefixed byte stream over a valid/ready handshake, packs bytes into 32-bit little-endian words, and writes them to consecutive instruction-memory addresses. It holds the CPU in reset until loading completes plus a fixed settle interval, then releases it. It replaces hard-coded memory init, so benches and boards can load arbitrary programs.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `HOLD_CYCLES`, 4: cycles `cpu_rst` stays high after the final write, ≥1.
- `clk_in`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  word for the write.
- `cpu_rst`  out  1  active-high reset to `top` (`rst` input of the core).
- `done`  out  1  load finished, CPU released; sticky until reset.
- `err`  out  1  length exceeded capacity; sticky until reset.

## Operation
- Stream format: 2-byte word count N (low byte first), then 4·N bytes, each word little-endian (first byte → bits 7:0).
- A byte is accepted on a rising edge with `in_valid && in_ready`. `in_data` is ignored otherwise.
- FSM states and transitions:
  - `LEN_LO`: reset state. Capture low byte, go to `LEN_HI`.
  - `LEN_HI`: capture high byte.
    - N = 0 → `HOLD`.
    - N > 2^ADDR_W → `ERR`.
    - Otherwise → `DATA`.
  - `DATA`: byte counter 0..3 fills the word. On the 4th byte, write word and increment word counter.
    - After word N-1 → `HOLD`.
  - `HOLD`: count HOLD_CYCLES, then → `RUN`.
  - `RUN`: terminal. `cpu_rst` = 0, `done` = 1.
  - `ERR`: terminal. `err` = 1, `cpu_rst` stays 1.
- `in_ready` = 1 only in `LEN_LO`, `LEN_HI`, `DATA`. It is 0 in `HOLD`/`RUN`/`ERR`, so extra bytes stall upstream.
- Word addresses start at 0 and increment by 1 per write. N = 2^ADDR_W is legal; the last address is 2^ADDR_W−1 and the counter never wraps into a second write.
- Length is compared as a 17-bit value, so N up to 65535 is checked without overflow.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_rst` 1, `done` 0, `err` 0.
- `in_ready` rises on the first edge after `rst` deasserts.
- Write latency: `imem_we`, `imem_addr`, and `imem_wdata` are registered. They assert for exactly one cycle, the cycle after the edge that accepted byte 3 of a word.
- Back-to-back bytes at full rate give one write every 4 cycles. Gaps in `in_valid` stall only the byte counter.
- `cpu_rst` falls exactly HOLD_CYCLES edges after the edge on which the last `imem_we` was high. For N = 0, it falls HOLD_CYCLES edges after the `LEN_HI` accept. `done` rises on the same edge.
- Reset mid-load is asynchronous:
  - `cpu_rst` re-asserts and all other outputs clear immediately, without waiting for a clock edge.
  - A partially assembled word is discarded.
  - Loading restarts from `LEN_LO` at address 0.

## Structure
- Shared package `boot_pkg`:
  - FSM state enum.
  - Byte-lane constants.
  - `BOOT_LEN_BYTES` = 2.
- One natural sub-module, `byte_word_packer`: shift-in of 4 bytes with a count; flags a full 32-bit word. The FSM, counters, and hold timer stay in `imem_boot_loader`.
- `top` instantiates the loader, ties `cpu_rst` to the core reset, and muxes `imem_we`/`imem_addr`/`imem_wdata` onto the instruction-memory write port.

## Test plan
- N = 2, bytes 0x02,0x00, 0x13,0x00,0x00,0x00, 0x93,0x00,0x10,0x00 at full rate → writes addr0 = 0x00000013 and addr1 = 0x00100093. `cpu_rst` falls 4 cycles after the second strobe. `done` = 1.
- Same stream with `in_valid` toggled every other cycle → identical writes and data, with strobes spaced 8 cycles apart.
- N = 0 (0x00,0x00) → no `imem_we`. `cpu_rst` falls HOLD_CYCLES cycles after the second byte. `in_ready` = 0 afterwards.
- ADDR_W = 2, N = 5 → `err` = 1, no writes, `cpu_rst` stays 1, `in_ready` = 0. With N = 4: writes to addresses 0..3, then `done`.
- `rst` driven low between bytes 2 and 3 of word 1 → `cpu_rst` = 1 and outputs clear immediately. A reload of N = 1 with 0xDEADBEEF writes addr0 = 0xDEADBEEF.
- 3 extra bytes held valid after the last word → `in_ready` stays 0 and no additional `imem_we` occurs.
